// File: rtl/stream_demux.sv
// Registered 1:NOUT valid/ready demultiplexer with a single-entry output register.
// Packet locking is compiled in when STREAM_DEMUX_PKT_LOCK_EN is defined.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 2,
    localparam int SEL_W = $clog2(NOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NOUT-1:0]         out_valid,
    input  logic [NOUT-1:0]         out_ready,
    output logic [NOUT*WIDTH-1:0]   out_data,
    output logic [NOUT-1:0]         out_last,
    output logic                    err
);

    localparam logic [SEL_W:0] NOUT_L = (SEL_W + 1)'(NOUT);

    logic               full_q, full_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               last_q, last_d;
    logic [SEL_W-1:0]   dest_q, dest_d;
    logic               err_q, err_d;

    logic               drain;
    logic               accept;
    logic               legal;
    logic [SEL_W-1:0]   eff_sel;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        eff_sel    = in_sel;
        if (state_q == LOCKED) begin
            eff_sel = lock_sel_q;
        end
        if (accept) begin
            case (state_q)
                IDLE: begin
                    lock_sel_d = in_sel;
                    if (!in_last) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
`else
    always_comb begin
        eff_sel = in_sel;
    end
`endif

    // in_ready deliberately ignores the new beat's destination (head-of-line blocking)
    assign drain    = full_q && out_ready[dest_q];
    assign in_ready = !full_q || drain;
    assign accept   = in_valid && in_ready;
    assign legal    = {1'b0, eff_sel} < NOUT_L;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        dest_d = dest_q;
        err_d  = err_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (accept) begin
            if (legal) begin
                full_d = 1'b1;
                data_d = in_data;
                last_d = in_last;
                dest_d = eff_sel;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= '0;
            err_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
            dest_q <= dest_d;
            err_q  <= err_d;
        end
    end

    for (genvar gi = 0; gi < NOUT; gi++) begin : g_port
        assign out_valid[gi]                 = full_q && (dest_q == SEL_W'(gi));
        assign out_last[gi]                  = full_q && (dest_q == SEL_W'(gi)) && last_q;
        assign out_data[gi*WIDTH +: WIDTH]   = data_q;
    end

    assign err = err_q;

endmodule
